// File: rtl/fft2d_pass_sequencer.sv
// Drives one 1-D FFT unit through a full 2-D transform: N row lines, then
// N column lines. Each line gets a unit reset, a one-cycle start with the
// pass sequence code, and a watchdog-guarded run until the unit reports done.
module fft2d_pass_sequencer #(
    parameter int                LOG_N      = 4,
    parameter int                SEQ_W      = 3,
    parameter logic [SEQ_W-1:0]  SEQ_ROW    = SEQ_W'(1),
    parameter logic [SEQ_W-1:0]  SEQ_COL    = SEQ_W'(2),
    parameter int                RST_CYCLES = 2,
    parameter int                TIMEOUT_W  = 12
) (
    input  logic                 i_fft_base_clock,
    input  logic                 i_fft_reset,
    input  logic                 i_start,
    input  logic                 i_inverse,
    input  logic                 i_unit_done,
    output logic [SEQ_W+1:0]     o_command,
    output logic                 o_controlIFFT,
    output logic                 o_pass,
    output logic [LOG_N-1:0]     o_line,
    output logic [2*LOG_N-1:0]   o_line_base,
    output logic [2*LOG_N-1:0]   o_stride,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_error
);
    localparam int AW   = 2 * LOG_N;
    localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RC_W-1:0]  RC_LAST    = RC_W'(RST_CYCLES - 1);
    localparam logic [AW-1:0]    STRIDE_ROW = AW'(1);
    localparam logic [AW-1:0]    STRIDE_COL = AW'(1 << LOG_N);
    // Unit held in reset, not started, neutral sequence.
    localparam logic [SEQ_W+1:0] CMD_HOLD   = {1'b1, 1'b0, {SEQ_W{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE, S_URST, S_LAUNCH, S_RUN, S_ADV, S_DONE, S_ERROR
    } state_t;

    state_t                state, state_nxt;
    logic [RC_W-1:0]       rcnt, rcnt_nxt;
    logic [TIMEOUT_W-1:0]  wd, wd_nxt, wd_inc;
    logic [SEQ_W+1:0]      cmd_nxt;
    logic [SEQ_W-1:0]      seq_code;
    logic                  ctrl_nxt, pass_nxt, busy_nxt, done_nxt, err_nxt;
    logic [LOG_N-1:0]      line_nxt;

    // Row lines are contiguous rows of the N x N buffer; column lines step by N.
    assign o_line_base = o_pass ? {{LOG_N{1'b0}}, o_line} : {o_line, {LOG_N{1'b0}}};
    assign o_stride    = o_pass ? STRIDE_COL : STRIDE_ROW;

    // Next-state and next-output decode; command is decoded from the current
    // state so it lands on the unit one cycle after the state is entered.
    always_comb begin
        state_nxt = state;
        rcnt_nxt  = rcnt;
        wd_nxt    = wd;
        ctrl_nxt  = o_controlIFFT;
        pass_nxt  = o_pass;
        line_nxt  = o_line;
        busy_nxt  = o_busy;
        err_nxt   = o_error;
        done_nxt  = 1'b0;
        wd_inc    = wd + TIMEOUT_W'(1);
        seq_code  = o_pass ? SEQ_COL : SEQ_ROW;

        case (state)
            S_URST:   cmd_nxt = {1'b1, 1'b0, seq_code};
            S_LAUNCH: cmd_nxt = {1'b0, 1'b1, seq_code};
            S_RUN,
            S_ADV:    cmd_nxt = {1'b0, 1'b0, seq_code};
            default:  cmd_nxt = CMD_HOLD;
        endcase

        case (state)
            S_IDLE, S_ERROR: begin
                if (i_start) begin
                    ctrl_nxt  = i_inverse;
                    pass_nxt  = 1'b0;
                    line_nxt  = '0;
                    err_nxt   = 1'b0;
                    busy_nxt  = 1'b1;
                    rcnt_nxt  = '0;
                    state_nxt = S_URST;
                end
            end
            S_URST: begin
                if (rcnt == RC_LAST) begin
                    rcnt_nxt  = '0;
                    state_nxt = S_LAUNCH;
                end else begin
                    rcnt_nxt  = rcnt + RC_W'(1);
                end
            end
            S_LAUNCH: begin
                wd_nxt    = '0;
                state_nxt = S_RUN;
            end
            S_RUN: begin
                wd_nxt = wd_inc;
                // Done takes priority over a watchdog expiring in the same cycle.
                if (i_unit_done) begin
                    state_nxt = S_ADV;
                end else if (wd_inc == '1) begin
                    err_nxt   = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = S_ERROR;
                end
            end
            S_ADV: begin
                if (o_line != '1) begin
                    line_nxt  = o_line + LOG_N'(1);
                    state_nxt = S_URST;
                end else if (!o_pass) begin
                    pass_nxt  = 1'b1;
                    line_nxt  = '0;
                    state_nxt = S_URST;
                end else begin
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // State and output registers; reset abandons any job silently.
    always_ff @(posedge i_fft_base_clock) begin
        if (i_fft_reset) begin
            state         <= S_IDLE;
            rcnt          <= '0;
            wd            <= '0;
            o_command     <= CMD_HOLD;
            o_controlIFFT <= 1'b0;
            o_pass        <= 1'b0;
            o_line        <= '0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_error       <= 1'b0;
        end else begin
            state         <= state_nxt;
            rcnt          <= rcnt_nxt;
            wd            <= wd_nxt;
            o_command     <= cmd_nxt;
            o_controlIFFT <= ctrl_nxt;
            o_pass        <= pass_nxt;
            o_line        <= line_nxt;
            o_busy        <= busy_nxt;
            o_done        <= done_nxt;
            o_error       <= err_nxt;
        end
    end
endmodule

// File: doc/fft2d_pass_sequencer.md
Name: fft2d_pass_sequencer

Overview:
Sequences the 1-D FFT unit through a full 2-D transform: N row transforms, then N column transforms, each launched through the unit's {reset, start, sequence} command word. It tracks line index and pass, and supplies the line base address and stride used to offset the unit's RAM addresses. It also drives the inverse-transform control, and flags a watchdog error if the unit never reports completion. It sits between the top-level 2-D FFT control and one 1-D FFT unit.

Parameters:
LOG_N, 4, log2 of lines per pass and points per line (N = 2^LOG_N)
SEQ_W, 3, width of the unit's sequence-mode field
SEQ_ROW, 3'd1, sequence code issued for row passes
SEQ_COL, 3'd2, sequence code issued for column passes
RST_CYCLES, 2, cycles the unit reset bit is held before each line (>=1)
TIMEOUT_W, 12, width of the per-line watchdog counter

Ports:
i_fft_base_clock  in   1            single clock, rising edge
i_fft_reset       in   1            synchronous active-high reset
i_start           in   1            one-cycle request to run a 2-D transform
i_inverse         in   1            sampled on accepted i_start: 1 = IFFT
i_unit_done       in   1            termination pulse from the 1-D unit
o_command         out  SEQ_W+2      {unit_reset, unit_start, sequence} to the 1-D unit
o_controlIFFT     out  1            inverse control to the unit, held for the whole job
o_pass            out  1            0 = row pass, 1 = column pass
o_line            out  LOG_N        current line index
o_line_base       out  2*LOG_N      row: line*N; column: line
o_stride          out  2*LOG_N      row: 1; column: N
o_busy            out  1            high from accepted start until DONE or ERROR
o_done            out  1            one-cycle pulse when all 2N lines are complete
o_error           out  1            sticky watchdog flag; cleared by reset or next accepted start

Behaviour:
- Reset (sync, any state): state=IDLE; o_command = {1'b1, 1'b0, SEQ_W'b0} (unit held in reset); o_controlIFFT=0; o_pass=0; o_line=0; o_busy=0; o_done=0; o_error=0; watchdog=0.
- States: IDLE, URST, LAUNCH, RUN, ADV, DONE, ERROR.
- IDLE: o_command={1,0,0}. On i_start: latch i_inverse into o_controlIFFT; o_pass=0; o_line=0; o_error=0; o_busy=1; go to URST.
- URST: unit_reset=1, unit_start=0, sequence = pass code. Hold for exactly RST_CYCLES cycles (counter), then go to LAUNCH.
- LAUNCH: one cycle with unit_reset=0, unit_start=1, and sequence = SEQ_ROW if o_pass=0, SEQ_COL if o_pass=1. Clear the watchdog and go to RUN.
- RUN: unit_reset=0, unit_start=0, sequence held. The watchdog increments each cycle.
  - i_unit_done=1: go to ADV.
  - Watchdog reaches all-ones without done: set o_error and go to ERROR.
  - Done wins if both occur in the same cycle.
- ADV (one cycle):
  - o_line < N-1: o_line+1, go to URST.
  - o_line = N-1 and o_pass=0: o_pass=1, o_line=0, go to URST.
  - o_line = N-1 and o_pass=1: go to DONE.
- DONE: o_done=1 for one cycle; o_busy=0; o_command returns to {1,0,0}; go to IDLE. o_pass and o_line keep their final values until the next start.
- ERROR: o_command={1,0,0}; o_busy=0; o_error stays high; wait for i_start (handled as in IDLE) or reset.
- i_start while busy: ignored; no state change.
- i_unit_done outside RUN: ignored.
- o_line_base and o_stride: combinational from o_pass and o_line, zero-extended to 2*LOG_N bits; no wrap is possible.
- o_command: registered, so each change appears the cycle after the state is entered.
- Latency, start to first unit_start: 1 (IDLE->URST) + RST_CYCLES + 1 cycles.
- Per-line overhead beyond the unit's run time: RST_CYCLES + 2 cycles.
- Reset mid-job: the job is abandoned immediately, with no o_done or o_error.

Test Plan:
1. Reset, then i_start=1, i_inverse=0. The bench model pulses done 10 cycles after each unit_start. Required: 32 unit_start pulses; lines 0..15 with pass=0 (base 0,16,..,240; stride 1), then pass=1 (base 0..15; stride 16); exactly one o_done; o_controlIFFT=0 throughout.
2. Same run with i_inverse=1, and i_inverse toggled mid-job. Required: o_controlIFFT=1 for the whole job and 0 after the next reset.
3. Model never asserts done on row line 3. Required: o_error=1 after 4095 RUN cycles; state ERROR; o_command={1,0,0}; no o_done. A following i_start clears o_error and restarts at line 0, pass 0.
4. Extra i_start pulses during RUN, and i_unit_done pulses during URST. Required: no effect; sequence identical to scenario 1.
5. Assert i_fft_reset during column pass line 7. Required: next cycle o_busy=0, o_line=0, o_pass=0, o_command={1,0,0}, and no o_done.
6. RST_CYCLES=1 and LOG_N=2 build, with done arriving in the same cycle the watchdog saturates. Required: 8 lines, done honoured (no error), and start-to-first-unit_start latency of exactly 3 cycles.
